wb_commit_queue: RTL and testbench
==================================

# wb_commit_queue

Parametrised writeback stage that replaces the single-register WB latch with a DEPTH-entry in-order commit queue. Entries arrive from the MEM stage and drain to the register-file write port under a ready handshake, so the register file may stall writeback. Each entry carries byte-lane write strobes. The block exposes NRP read-port lookups that forward data to ID or raise a stall. Debug trace outputs describe each committed write.

## Interface
Parameters:
- DATA_W, 32, register data width; multiple of 8
- ADDR_W, 5, register address width
- PC_W, 32, PC width
- DEPTH, 2, queue entries; power of two, ≥2
- NRP, 2, number of ID-stage lookup ports

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- mem_to_wb_valid  in  1  MEM offers an entry
- wb_allowin  out  1  queue can accept this cycle; equals count < DEPTH
- mem_pc  in  PC_W  PC of the offered entry
- mem_rf_strb  in  DATA_W/8  byte write strobes
- mem_rf_waddr  in  ADDR_W  destination register
- mem_rf_wdata  in  DATA_W  write data
- flush  in  1  discard all queued entries
- rf_we  out  DATA_W/8  strobes presented to the register file
- rf_waddr  out  ADDR_W  head destination
- rf_wdata  out  DATA_W  head data
- rf_wready  in  1  register file accepts the head write this cycle
- wb_valid  out  1  queue non-empty
- id_raddr  in  NRP*ADDR_W  lookup addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- fwd_hit  out  NRP  per-port forward valid
- fwd_data  out  NRP*DATA_W  per-port forwarded data
- fwd_stall  out  NRP  per-port partial-write hazard
- debug_wb_pc  out  PC_W  committed PC
- debug_wb_rf_we  out  DATA_W/8  committed strobes; zero when no commit
- debug_wb_rf_wnum  out  ADDR_W  committed register
- debug_wb_rf_wdata  out  DATA_W  committed data

## Operation
- Storage: circular buffer with head/tail pointers of width log2(DEPTH) that wrap modulo DEPTH, plus a count of width log2(DEPTH)+1.
- Push: when mem_to_wb_valid & wb_allowin, the entry is written at tail, tail advances and count increments.
- Entries with mem_rf_waddr==0 are stored with all-zero strobes, so writes to r0 never reach the register file.
- Head presentation: rf_we = head strobes when count>0, else 0. rf_waddr and rf_wdata show the head entry whenever count>0 and are don't-care when empty.
- Pop (commit): when count>0 & rf_wready, head advances and count decrements. Entries whose strobes are all zero still need rf_wready to pop.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- wb_allowin depends only on count. It has no combinational path from rf_wready, so a full queue does not accept an entry in the same cycle that it pops one.
- Flush: next cycle count=0 and head=tail=0. A push in the flush cycle is dropped. A pop in the flush cycle still commits, and its debug outputs fire.
- Forwarding, per port i, all combinational:
  - Search the valid entries from youngest to oldest for the first one with waddr==id_raddr[i] and non-zero strobes.
  - If that entry's strobes are all ones: fwd_hit=1 and fwd_data=its data.
  - If its strobes are partial: fwd_stall=1 and fwd_hit=0.
  - If there is no match, or id_raddr[i]==0: both flags are 0 and fwd_data=0.
- Debug outputs are registered from the committing entry:
  - On a pop, the cycle after shows that entry's pc, strobes, waddr and data.
  - Otherwise debug_wb_rf_we=0 and the other debug fields hold their last value.

## Timing
- Reset: count, pointers, wb_valid=0. rf_we=0, fwd_hit=0, fwd_stall=0, fwd_data=0, debug_wb_rf_we=0, debug_wb_pc=0, debug_wb_rf_wnum=0, debug_wb_rf_wdata=0. wb_allowin=1 in the first cycle after reset. Reset overrides flush, push and pop.
- Latency:
  - An entry pushed in cycle N is at the head and visible to forwarding from cycle N+1.
  - If rf_wready=1 in cycle N+1, the entry commits in N+1 and the debug outputs show it in N+2.
- Throughput: one entry per cycle when rf_wready is held at 1; the queue never fills in that case.
- Back-pressure: with rf_wready=0, DEPTH consecutive pushes fill the queue and wb_allowin drops in the cycle after the DEPTH-th push. It rises one cycle after the first pop.

## Test plan
- Streaming: 8 back-to-back pushes (waddr 1..8, data 0x100+k, strobes 0xF) with rf_wready=1.
  - Expect debug_wb_rf_we=0xF for 8 consecutive cycles, starting 2 cycles after the first push, with wnum 1..8 in order and wb_allowin always 1.
- Fill and drain: rf_wready=0, push 3 entries with DEPTH=2.
  - wb_allowin=0 after the 2nd push and the 3rd entry is held by MEM.
  - Raise rf_wready: commits occur in order 1, 2, 3 and the pointers wrap correctly.
- Forwarding: queue holds {r5, 0xAAAA_AAAA, 0xF} older and {r5, 0x1234_5678, 0xF} younger; id_raddr = r5, r6.
  - Port 0: fwd_hit=1, fwd_data=0x1234_5678.
  - Port 1: fwd_hit=0.
- Partial write: the youngest matching r7 entry has strobes 0x3 → fwd_stall=1 and fwd_hit=0 on that port.
- r0 write: push {waddr 0, strobes 0xF} → the entry pops, rf_we=0 while it is at the head, debug_wb_rf_we=0, and a lookup of r0 gives no hit.
- Flush and reset mid-operation:
  - Queue full with rf_wready=0, assert flush → count=0 and wb_allowin=1 next cycle, with no further commits.
  - Repeat the full-queue setup using reset in place of flush → all outputs return to their reset values.

Source files
------------

// File: rtl/wb_commit_queue_if.sv
// Bundle of MEM-side push, register-file write, ID lookup and debug trace
// signals for wb_commit_queue.
//   master : the environment side (MEM stage, register file, ID stage)
//   slave  : the commit queue itself
interface wb_commit_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32,
  parameter int NRP    = 2
);
  localparam int STRB_W = DATA_W / 8;

  // MEM -> queue
  logic                     mem_to_wb_valid;
  logic                     wb_allowin;
  logic [PC_W-1:0]          mem_pc;
  logic [STRB_W-1:0]        mem_rf_strb;
  logic [ADDR_W-1:0]        mem_rf_waddr;
  logic [DATA_W-1:0]        mem_rf_wdata;
  logic                     flush;
  // queue head -> register file
  logic [STRB_W-1:0]        rf_we;
  logic [ADDR_W-1:0]        rf_waddr;
  logic [DATA_W-1:0]        rf_wdata;
  logic                     rf_wready;
  logic                     wb_valid;
  // ID-stage lookups
  logic [NRP*ADDR_W-1:0]    id_raddr;
  logic [NRP-1:0]           fwd_hit;
  logic [NRP*DATA_W-1:0]    fwd_data;
  logic [NRP-1:0]           fwd_stall;
  // commit trace
  logic [PC_W-1:0]          debug_wb_pc;
  logic [STRB_W-1:0]        debug_wb_rf_we;
  logic [ADDR_W-1:0]        debug_wb_rf_wnum;
  logic [DATA_W-1:0]        debug_wb_rf_wdata;

  modport master (
    output mem_to_wb_valid, mem_pc, mem_rf_strb, mem_rf_waddr, mem_rf_wdata,
           flush, rf_wready, id_raddr,
    input  wb_allowin, rf_we, rf_waddr, rf_wdata, wb_valid,
           fwd_hit, fwd_data, fwd_stall,
           debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  modport slave (
    input  mem_to_wb_valid, mem_pc, mem_rf_strb, mem_rf_waddr, mem_rf_wdata,
           flush, rf_wready, id_raddr,
    output wb_allowin, rf_we, rf_waddr, rf_wdata, wb_valid,
           fwd_hit, fwd_data, fwd_stall,
           debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
  );
endinterface

// File: rtl/wb_commit_queue.sv
// In-order writeback commit queue (DEPTH entries) between MEM and the
// register-file write port, with per-port ID forwarding and a registered
// commit trace.
//   clk   : clock, all state on posedge
//   reset : synchronous, active-high
//   bus   : wb_commit_queue_if.slave (push, rf write, lookups, debug)

// One ID lookup port. Entries arrive ordered youngest (index 0) to oldest.
module wb_commit_fwd #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic [ADDR_W-1:0]                raddr_i,
  input  logic [DEPTH-1:0]                 vld_i,
  input  logic [DEPTH-1:0][ADDR_W-1:0]     waddr_i,
  input  logic [DEPTH-1:0][DATA_W/8-1:0]   strb_i,
  input  logic [DEPTH-1:0][DATA_W-1:0]     data_i,
  output logic                             hit_o,
  output logic                             stall_o,
  output logic [DATA_W-1:0]                data_o
);
  logic found;

  // First non-zero-strobe match wins; a partial write cannot be forwarded.
  always_comb begin
    hit_o   = 1'b0;
    stall_o = 1'b0;
    data_o  = '0;
    found   = 1'b0;
    if (raddr_i != '0) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!found && vld_i[k] && (waddr_i[k] == raddr_i) && (|strb_i[k])) begin
          found = 1'b1;
          if (&strb_i[k]) begin
            hit_o  = 1'b1;
            data_o = data_i[k];
          end else begin
            stall_o = 1'b1;
          end
        end
      end
    end
  end
endmodule

module wb_commit_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 2,
  parameter int NRP    = 2
) (
  input  logic               clk,
  input  logic               reset,
  wb_commit_queue_if.slave   bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [STRB_W-1:0] strb;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            ent_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  entry_t            dbg_q, dbg_d;
  entry_t            head_ent, new_ent;
  logic              nempty, push, pop;

  assign nempty   = (cnt_q != '0);
  assign head_ent = ent_q[head_q];
  // allowin is a pure function of count: a full queue never takes an entry
  // in the cycle it pops.
  assign bus.wb_allowin = (cnt_q < CNT_W'(DEPTH));
  assign push = bus.mem_to_wb_valid & bus.wb_allowin & ~bus.flush;
  assign pop  = nempty & bus.rf_wready;

  // r0 writes are kept in order but neutered so they never reach the RF.
  always_comb begin
    new_ent.pc    = bus.mem_pc;
    new_ent.strb  = (bus.mem_rf_waddr == '0) ? '0 : bus.mem_rf_strb;
    new_ent.waddr = bus.mem_rf_waddr;
    new_ent.data  = bus.mem_rf_wdata;
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (push) tail_d = tail_q + PTR_W'(1);
    if (pop)  head_d = head_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    // A pop in the flush cycle still commits (trace below), only state clears.
    if (bus.flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
  end

  always_comb begin
    dbg_d      = dbg_q;
    dbg_d.strb = '0;
    if (pop) dbg_d = head_ent;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      dbg_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      dbg_q  <= dbg_d;
    end
  end

  // Payload storage needs no reset: it is only observed while counted.
  always_ff @(posedge clk) begin
    if (push) ent_q[tail_q] <= new_ent;
  end

  assign bus.wb_valid = nempty;
  assign bus.rf_we    = nempty ? head_ent.strb : '0;
  assign bus.rf_waddr = head_ent.waddr;
  assign bus.rf_wdata = head_ent.data;

  assign bus.debug_wb_pc       = dbg_q.pc;
  assign bus.debug_wb_rf_we    = dbg_q.strb;
  assign bus.debug_wb_rf_wnum  = dbg_q.waddr;
  assign bus.debug_wb_rf_wdata = dbg_q.data;

  // Re-order the ring by age (0 = youngest) for the lookup ports.
  logic [DEPTH-1:0]               age_vld;
  logic [DEPTH-1:0][ADDR_W-1:0]   age_waddr;
  logic [DEPTH-1:0][STRB_W-1:0]   age_strb;
  logic [DEPTH-1:0][DATA_W-1:0]   age_data;

  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    logic [PTR_W-1:0] idx;
    assign idx          = tail_q - PTR_W'(k + 1);
    assign age_vld[k]   = (cnt_q > CNT_W'(k));
    assign age_waddr[k] = ent_q[idx].waddr;
    assign age_strb[k]  = ent_q[idx].strb;
    assign age_data[k]  = ent_q[idx].data;
  end

  for (genvar p = 0; p < NRP; p++) begin : g_fwd
    wb_commit_fwd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fwd (
      .raddr_i (bus.id_raddr[p*ADDR_W +: ADDR_W]),
      .vld_i   (age_vld),
      .waddr_i (age_waddr),
      .strb_i  (age_strb),
      .data_i  (age_data),
      .hit_o   (bus.fwd_hit[p]),
      .stall_o (bus.fwd_stall[p]),
      .data_o  (bus.fwd_data[p*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_wb_commit_queue.sv
// Directed bench for wb_commit_queue: a queue-based reference model is
// compared against every DUT output on each negedge, and literal
// expectations pin the model at key points of each scenario.
module tb_wb_commit_queue;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int PC_W   = 32;
  localparam int DEPTH  = 2;
  localparam int NRP    = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wb_commit_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .NRP(NRP)) bus ();

  wb_commit_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W),
                    .DEPTH(DEPTH), .NRP(NRP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  strb;
    logic [4:0]  waddr;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] e_pc, e_data;
  logic [3:0]  e_we;
  logic [4:0]  e_wnum;
  int          vec = 0;
  int          mis = 0;
  int          cyc = 0;
  bit          en  = 0;
  logic [4:0]  clog[$];
  int          ccyc[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: an in-order list of entries updated per the queue rules.
  ent_t m_e;
  bit   m_pop, m_push;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      mq.delete();
      e_pc = 0; e_data = 0; e_we = 0; e_wnum = 0;
    end else begin
      m_pop  = (mq.size() > 0) && bus.rf_wready;
      m_push = bus.mem_to_wb_valid && (mq.size() < DEPTH) && !bus.flush;
      e_we = 4'h0;
      if (m_pop) begin
        m_e    = mq.pop_front();
        e_pc   = m_e.pc;
        e_we   = m_e.strb;
        e_wnum = m_e.waddr;
        e_data = m_e.data;
      end
      if (bus.flush) mq.delete();
      else if (m_push) begin
        m_e.pc    = bus.mem_pc;
        m_e.waddr = bus.mem_rf_waddr;
        m_e.strb  = (bus.mem_rf_waddr == 0) ? 4'h0 : bus.mem_rf_strb;
        m_e.data  = bus.mem_rf_wdata;
        mq.push_back(m_e);
      end
    end
  end

  // Per-cycle comparison against the model.
  int          c_n;
  logic [4:0]  c_ra;
  logic        c_hit, c_stall;
  logic [31:0] c_data;
  always @(negedge clk) begin
    if (en) begin
      c_n = mq.size();
      chk("allowin", bus.wb_allowin, (c_n < DEPTH) ? 1 : 0);
      chk("wb_valid", bus.wb_valid, (c_n > 0) ? 1 : 0);
      if (c_n > 0) begin
        chk("rf_we", bus.rf_we, mq[0].strb);
        chk("rf_waddr", bus.rf_waddr, mq[0].waddr);
        chk("rf_wdata", bus.rf_wdata, mq[0].data);
      end else begin
        chk("rf_we_empty", bus.rf_we, 0);
      end
      for (int p = 0; p < NRP; p++) begin
        c_ra = bus.id_raddr[p*ADDR_W +: ADDR_W];
        c_hit = 0; c_stall = 0; c_data = 0;
        if (c_ra != 0) begin
          for (int j = c_n - 1; j >= 0; j--) begin
            if (mq[j].waddr == c_ra && mq[j].strb != 0) begin
              if (mq[j].strb == 4'hF) begin c_hit = 1; c_data = mq[j].data; end
              else c_stall = 1;
              break;
            end
          end
        end
        chk("fwd_hit", bus.fwd_hit[p], c_hit);
        chk("fwd_stall", bus.fwd_stall[p], c_stall);
        if (!c_stall) chk("fwd_data", bus.fwd_data[p*DATA_W +: DATA_W], c_data);
      end
      chk("dbg_we", bus.debug_wb_rf_we, e_we);
      chk("dbg_pc", bus.debug_wb_pc, e_pc);
      chk("dbg_wnum", bus.debug_wb_rf_wnum, e_wnum);
      chk("dbg_wdata", bus.debug_wb_rf_wdata, e_data);
      if (bus.debug_wb_rf_we != 0) begin
        clog.push_back(bus.debug_wb_rf_wnum);
        ccyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ent(input logic [4:0] wa, input logic [3:0] st, input logic [31:0] d);
    bus.mem_pc       = 32'h8000_0000 | d;
    bus.mem_rf_waddr = wa;
    bus.mem_rf_strb  = st;
    bus.mem_rf_wdata = d;
  endtask

  // Offer one entry and hold it until accepted; leaves valid asserted.
  task automatic push_one(input logic [4:0] wa, input logic [3:0] st, input logic [31:0] d);
    bit acc;
    int t;
    set_ent(wa, st, d);
    bus.mem_to_wb_valid = 1'b1;
    t = 0;
    do begin
      acc = bus.wb_allowin;
      step();
      t++;
    end while (!acc && t < 20);
    chk("push_accept", acc, 1);
  endtask

  int s;

  initial begin
    bus.mem_to_wb_valid = 0; bus.flush = 0; bus.rf_wready = 0; bus.id_raddr = '0;
    set_ent(5'd0, 4'h0, 32'h0);
    reset = 1;
    step(); step();
    en = 1;
    chk("rst_allowin", bus.wb_allowin, 1);
    chk("rst_valid", bus.wb_valid, 0);
    chk("rst_rf_we", bus.rf_we, 0);
    chk("rst_dbg_we", bus.debug_wb_rf_we, 0);
    chk("rst_dbg_pc", bus.debug_wb_pc, 0);
    reset = 0;
    step();

    // Streaming: 8 back-to-back entries with the RF always ready.
    bus.rf_wready = 1;
    clog.delete(); ccyc.delete();
    s = cyc;
    for (int k = 1; k <= 8; k++) push_one(5'(k), 4'hF, 32'(32'h100 + k));
    bus.mem_to_wb_valid = 0;
    repeat (4) step();
    chk("stream_count", clog.size(), 8);
    if (clog.size() == 8) begin
      for (int k = 0; k < 8; k++) chk("stream_wnum", clog[k], k + 1);
      chk("stream_first_cycle", ccyc[0], s + 2);
      chk("stream_span", ccyc[7] - ccyc[0], 7);
    end

    // Fill with the RF stalled, hold a third entry, then drain.
    bus.rf_wready = 0;
    clog.delete();
    push_one(5'd9, 4'hF, 32'h900);
    push_one(5'd10, 4'hF, 32'hA00);
    set_ent(5'd11, 4'hF, 32'hB00);
    chk("fill_allowin", bus.wb_allowin, 0);
    step(); step();
    chk("fill_allowin_held", bus.wb_allowin, 0);
    chk("fill_head", bus.rf_waddr, 9);
    bus.rf_wready = 1;
    push_one(5'd11, 4'hF, 32'hB00);
    bus.mem_to_wb_valid = 0;
    repeat (4) step();
    chk("drain_count", clog.size(), 3);
    if (clog.size() == 3) begin
      chk("drain_0", clog[0], 9);
      chk("drain_1", clog[1], 10);
      chk("drain_2", clog[2], 11);
    end

    // Forwarding: the younger r5 wins, r6 misses.
    bus.rf_wready = 0;
    push_one(5'd5, 4'hF, 32'hAAAA_AAAA);
    push_one(5'd5, 4'hF, 32'h1234_5678);
    bus.mem_to_wb_valid = 0;
    bus.id_raddr = {5'd6, 5'd5};
    #1;
    chk("fwd0_hit", bus.fwd_hit[0], 1);
    chk("fwd0_data", bus.fwd_data[31:0], 32'h1234_5678);
    chk("fwd1_hit", bus.fwd_hit[1], 0);
    chk("fwd1_stall", bus.fwd_stall[1], 0);
    bus.rf_wready = 1;
    repeat (3) step();

    // Partial write on the youngest r7 forces a stall.
    bus.rf_wready = 0;
    push_one(5'd7, 4'hF, 32'h1111_1111);
    push_one(5'd7, 4'h3, 32'h0000_BEEF);
    bus.mem_to_wb_valid = 0;
    bus.id_raddr = {5'd5, 5'd7};
    #1;
    chk("part_stall", bus.fwd_stall[0], 1);
    chk("part_hit", bus.fwd_hit[0], 0);
    chk("part_other_hit", bus.fwd_hit[1], 0);
    bus.rf_wready = 1;
    repeat (3) step();

    // A younger zero-strobe r7 entry is skipped; the older full write hits.
    bus.rf_wready = 0;
    push_one(5'd7, 4'hF, 32'h0000_0055);
    push_one(5'd7, 4'h0, 32'h0000_0066);
    bus.mem_to_wb_valid = 0;
    #1;
    chk("zstrb_hit", bus.fwd_hit[0], 1);
    chk("zstrb_data", bus.fwd_data[31:0], 32'h55);
    bus.rf_wready = 1;
    repeat (3) step();

    // r0 write: kept in order, never written, never forwarded.
    bus.rf_wready = 0;
    push_one(5'd0, 4'hF, 32'h0000_DEAD);
    bus.mem_to_wb_valid = 0;
    bus.id_raddr = {5'd0, 5'd0};
    #1;
    chk("r0_valid", bus.wb_valid, 1);
    chk("r0_rf_we", bus.rf_we, 0);
    chk("r0_hit", bus.fwd_hit[0], 0);
    bus.rf_wready = 1;
    step();
    chk("r0_popped", bus.wb_valid, 0);
    chk("r0_dbg_we", bus.debug_wb_rf_we, 0);
    chk("r0_dbg_wdata", bus.debug_wb_rf_wdata, 32'hDEAD);
    step();

    // Flush a full queue: empty next cycle, nothing further commits.
    bus.rf_wready = 0;
    push_one(5'd12, 4'hF, 32'hC00);
    push_one(5'd13, 4'hF, 32'hD00);
    bus.mem_to_wb_valid = 0;
    clog.delete();
    bus.flush = 1;
    step();
    bus.flush = 0;
    chk("flush_allowin", bus.wb_allowin, 1);
    chk("flush_valid", bus.wb_valid, 0);
    bus.rf_wready = 1;
    repeat (3) step();
    chk("flush_no_commit", clog.size(), 0);

    // Flush cycle with a pop and a push: pop commits, push is dropped.
    bus.rf_wready = 0;
    push_one(5'd14, 4'hF, 32'hE00);
    set_ent(5'd15, 4'hF, 32'hF00);
    bus.flush = 1;
    bus.rf_wready = 1;
    step();
    bus.flush = 0;
    bus.mem_to_wb_valid = 0;
    chk("fpop_valid", bus.wb_valid, 0);
    chk("fpop_dbg_wnum", bus.debug_wb_rf_wnum, 14);
    chk("fpop_dbg_we", bus.debug_wb_rf_we, 4'hF);
    step();

    // Reset a full queue mid-operation.
    bus.rf_wready = 0;
    push_one(5'd16, 4'hF, 32'h1600);
    push_one(5'd17, 4'h3, 32'h1700);
    bus.mem_to_wb_valid = 0;
    bus.id_raddr = {5'd17, 5'd16};
    reset = 1;
    step();
    reset = 0;
    chk("rs_allowin", bus.wb_allowin, 1);
    chk("rs_valid", bus.wb_valid, 0);
    chk("rs_rf_we", bus.rf_we, 0);
    chk("rs_fwd_hit", bus.fwd_hit, 0);
    chk("rs_fwd_stall", bus.fwd_stall, 0);
    chk("rs_fwd_data", bus.fwd_data, 0);
    chk("rs_dbg_we", bus.debug_wb_rf_we, 0);
    chk("rs_dbg_pc", bus.debug_wb_pc, 0);
    chk("rs_dbg_wnum", bus.debug_wb_rf_wnum, 0);
    chk("rs_dbg_wdata", bus.debug_wb_rf_wdata, 0);
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
